mem_port_arbiter: RTL and testbench

- Shares one synchronous single-port 16-bit word RAM between two requesters.
  - Port 0: the stack CPU (instruction fetch plus data load/store).
  - Port 1: a secondary master (program loader / debug / DMA).
- Round-robin arbitration, one access per cycle, fixed 1-cycle read latency.
- Optional lock lets a master hold the RAM for atomic read-modify-write sequences.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_rr2.sv | 92 +++++++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   PORT_CPU / PORT_AUX : port ids (stack CPU, secondary master)
//   lock_state_e        : lock FSM states
//   ADDR_W / DATA_W     : default word-address and data widths
package arb_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;
endpackage

// File: rtl/arb_rr2.sv
// 2-way round-robin grant logic with an ownership lock.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : per-port request
//   lock[1:0]  : per-port "keep ownership after this grant"
//   gnt[1:0]   : one-hot grant, combinational in the request cycle
// The lock is held for at most LOCK_MAX consecutive grants; the grant that
// reaches LOCK_MAX is still issued and then the lock drops.
module arb_rr2 #(
  parameter int LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);
  import arb_pkg::*;

  localparam logic [CNT_W-1:0] LMAX = CNT_W'(LOCK_MAX);

  lock_state_e      state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any, win;

  // Grant selection; nothing is granted while reset is asserted so no
  // write can reach the RAM during reset.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    win = last_q;
    if (rst_n) begin
      if (state_q == LOCKED) begin
        if (req[owner_q]) begin
          any = 1'b1;
          win = owner_q;
        end
      end else if (req[0] && req[1]) begin
        any = 1'b1;
        win = ~last_q;
      end else if (req[0]) begin
        any = 1'b1;
        win = PORT_CPU;
      end else if (req[1]) begin
        any = 1'b1;
        win = PORT_AUX;
      end
    end
    if (any) gnt[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (any) begin
      last_d = win;
      if (lock[win]) begin
        state_d = LOCKED;
        owner_d = win;
        cnt_d   = (state_q == LOCKED) ? cnt_q + 1'b1 : CNT_W'(1);
        if (cnt_d >= LMAX) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      end else begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    end else if (state_q == LOCKED) begin
      // owner let go of its request
      state_d = UNLOCKED;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      owner_q <= PORT_CPU;
      last_q  <= PORT_AUX;   // CPU wins the first contention
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port word RAM between the stack CPU (m0)
// and a secondary master (m1). One access per cycle, 1-cycle read latency.
//   mX_req/wr/lock/addr/wdata : master request side
//   mX_gnt                    : access accepted this cycle (combinational)
//   mX_rvalid/rdata           : read return, cycle after the grant
//   mem_addr/wdata/we/rdata   : RAM side (RAM must be write-first)
// Build option ARB_STATS_EN adds stat_clr, stat_gnt0, stat_gnt1 and
// stat_conflict (16-bit saturating counters).
module mem_port_arbiter #(
  parameter int ADDR_W   = arb_pkg::ADDR_W,
  parameter int DATA_W   = arb_pkg::DATA_W,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_conflict
`endif
);
  import arb_pkg::*;

  logic [1:0]             gnt;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   rd_pend_q, rd_port_q;
  logic [1:0][DATA_W-1:0] rdata_q;

  arb_rr2 #(.LOCK_MAX(LOCK_MAX)) u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({m1_req, m0_req}),
    .lock ({m1_lock, m0_lock}),
    .gnt  (gnt)
  );

  assign m0_gnt = gnt[PORT_CPU];
  assign m1_gnt = gnt[PORT_AUX];

  // Address/data follow the winner; they hold the last granted values
  // when idle so the RAM address bus stays quiet.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    if (gnt[PORT_CPU]) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_wr;
    end else if (gnt[PORT_AUX]) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT_CPU;
      rdata_q   <= '0;
    end else begin
      if (|gnt) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      rd_pend_q <= (|gnt) & ~mem_we;
      rd_port_q <= gnt[PORT_AUX];
      if (rd_pend_q) rdata_q[rd_port_q] <= mem_rdata;
    end
  end

  // RAM data passes straight through in the return cycle, then is held.
  assign m0_rvalid = rd_pend_q & (rd_port_q == PORT_CPU);
  assign m1_rvalid = rd_pend_q & (rd_port_q == PORT_AUX);
  assign m0_rdata  = m0_rvalid ? mem_rdata : rdata_q[PORT_CPU];
  assign m1_rdata  = m1_rvalid ? mem_rdata : rdata_q[PORT_AUX];

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else if (stat_clr) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt[PORT_CPU] && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
      if (gnt[PORT_AUX] && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
      if (m0_req && m1_req && stat_conflict != 16'hFFFF)
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first behavioural RAM.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
  logic [14:0] m0_addr, m1_addr, mem_addr;
  logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
`ifdef ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif
  logic [15:0] ram [0:255];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata          <= mem_wdata;
    end else begin
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
    .stat_conflict(stat_conflict)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic r0, w0, l0, input logic [14:0] a0, input logic [15:0] d0,
                     input logic r1, w1, l1, input logic [14:0] a1, input logic [15:0] d1);
    m0_req = r0; m0_wr = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wr = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 15'h0, 16'h0, 0, 0, 0, 15'h0, 16'h0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    // reset state, with m0 trying to write during reset
    drv(1, 1, 0, 15'h7, 16'hAAAA, 0, 0, 0, 15'h0, 16'h0);
    smp();
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rvalid0", m0_rvalid, 0);
    chk("rst_rdata0", m0_rdata, 0);
    nxt(); idle(); rst_n = 1'b1;

    // preload through the loader port
    nxt(); drv(0, 0, 0, 15'h0, 16'h0, 1, 1, 0, 15'h3, 16'h1234);
    smp();
    chk("pre_gnt1", m1_gnt, 1);
    chk("pre_we", mem_we, 1);
    nxt(); drv(0, 0, 0, 15'h0, 16'h0, 1, 1, 0, 15'h5, 16'h5555);
    smp();

    // single reader on m0
    nxt(); drv(1, 0, 0, 15'h3, 16'h0, 0, 0, 0, 15'h0, 16'h0);
    smp();
    chk("rd_gnt0", m0_gnt, 1);
    chk("rd_gnt1", m1_gnt, 0);
    chk("rd_addr", mem_addr, 15'h3);
    chk("rd_we", mem_we, 0);
    nxt(); idle();
    smp();
    chk("rd_rvalid0", m0_rvalid, 1);
    chk("rd_rdata0", m0_rdata, 16'h1234);
    chk("rd_rvalid1", m1_rvalid, 0);
    chk("idle_addr_hold", mem_addr, 15'h3);
    nxt();
    smp();
    chk("rd_rvalid0_off", m0_rvalid, 0);
    chk("rd_rdata0_hold", m0_rdata, 16'h1234);

    // reset the cycle after an m0 read grant
    nxt(); drv(1, 0, 0, 15'h3, 16'h0, 0, 0, 0, 15'h0, 16'h0);
    smp();
    chk("mr_gnt0", m0_gnt, 1);
    nxt(); rst_n = 1'b0; drv(1, 0, 0, 15'h3, 16'h0, 1, 1, 0, 15'h5, 16'hDEAD);
    smp();
    chk("mr_rvalid0", m0_rvalid, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_gnt1", m1_gnt, 0);

    // both read every cycle for 6 cycles: m0 first, then alternate
    nxt(); rst_n = 1'b1; drv(1, 0, 0, 15'h3, 16'h0, 1, 0, 0, 15'h5, 16'h0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) idle();
      smp();
      chk($sformatf("alt_gnt0_%0d", i), m0_gnt, (i < 6) && (i % 2 == 0));
      chk($sformatf("alt_gnt1_%0d", i), m1_gnt, (i < 6) && (i % 2 == 1));
      chk($sformatf("alt_rv0_%0d", i), m0_rvalid, (i >= 1) && (i % 2 == 1));
      chk($sformatf("alt_rv1_%0d", i), m1_rvalid, (i >= 2) && (i % 2 == 0));
      if (m0_rvalid) chk($sformatf("alt_rd0_%0d", i), m0_rdata, 16'h1234);
      if (m1_rvalid) chk($sformatf("alt_rd1_%0d", i), m1_rdata, 16'h5555);
      nxt();
    end

    // m1 writes, m0 reads the same address next cycle
    drv(0, 0, 0, 15'h0, 16'h0, 1, 1, 0, 15'h10, 16'hBEEF);
    smp();
    chk("raw_we", mem_we, 1);
    chk("raw_wdata", mem_wdata, 16'hBEEF);
    nxt(); drv(1, 0, 0, 15'h10, 16'h0, 0, 0, 0, 15'h0, 16'h0);
    smp();
    chk("raw_gnt0", m0_gnt, 1);
    nxt(); idle();
    smp();
    chk("raw_rvalid0", m0_rvalid, 1);
    chk("raw_rdata0", m0_rdata, 16'hBEEF);

    // m1 locks for 10 cycles while m0 keeps requesting (m0 won last)
    nxt(); drv(1, 0, 0, 15'h3, 16'h0, 1, 0, 1, 15'h5, 16'h0);
    for (int i = 0; i < 12; i++) begin
      if (i == 10) drv(1, 0, 0, 15'h3, 16'h0, 0, 0, 0, 15'h0, 16'h0);
      smp();
      if (i < 10) begin
        chk($sformatf("lk_gnt1_%0d", i), m1_gnt, i != 8);
        chk($sformatf("lk_gnt0_%0d", i), m0_gnt, i == 8);
      end else begin
        // owner dropped its request: one dead cycle, then m0
        chk($sformatf("lk_rel_gnt0_%0d", i), m0_gnt, i == 11);
        chk($sformatf("lk_rel_gnt1_%0d", i), m1_gnt, 0);
      end
      nxt();
    end
    idle();

`ifdef ARB_STATS_EN
    rst_n = 1'b0;
    nxt(); rst_n = 1'b1; drv(1, 0, 0, 15'h3, 16'h0, 1, 0, 0, 15'h5, 16'h0);
    for (int i = 0; i < 5; i++) begin
      smp();
      nxt();
    end
    idle(); stat_clr = 1'b1;
    smp();
    chk("st_conflict", stat_conflict, 5);
    chk("st_gnt_sum", 32'(stat_gnt0) + 32'(stat_gnt1), 5);
    chk("st_gnt0", stat_gnt0, 3);
    nxt(); stat_clr = 1'b0;
    smp();
    chk("st_clr_conflict", stat_conflict, 0);
    chk("st_clr_gnt0", stat_gnt0, 0);
    chk("st_clr_gnt1", stat_gnt1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
